iob_native_responder: RTL and testbench

IOb Native subordinate (responder) that accepts requests from an IOb Native initiator, such as a cache back-end or a testbench write/read task, and executes them on a single-port, byte-enabled synchronous RAM with one-cycle read latency. A programmable number of wait states is inserted before each `iob_ready_o` to exercise initiator back-pressure handling. It replaces ad-hoc RAM-plus-rvalid glue in simulation and serves as a reusable memory-side endpoint in systems.

---
 rtl/iob_native_responder_pkg.sv | 14 +
 rtl/iob_native_responder_stats.sv | 31 +++
 rtl/iob_native_responder.sv | 135 +++++++++++++
 tb/tb_iob_native_responder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_native_responder_pkg.sv
// Shared types and widths for the IOb Native responder.
package iob_native_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ACK   = 2'd2,
      ST_RDATA = 2'd3
   } state_t;

   localparam int CNT_W   = 8;
   localparam int STATS_W = 32;

endpackage

// File: rtl/iob_native_responder_stats.sv
// Read/write transaction counters for the IOb Native responder.
// Counters wrap freely; a clear wins over a same-cycle increment.
module iob_native_responder_stats
   import iob_native_responder_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               rd_inc_i,
   input  logic               wr_inc_i,
   output logic [STATS_W-1:0] rd_cnt_o,
   output logic [STATS_W-1:0] wr_cnt_o
);

   localparam logic [STATS_W-1:0] STATS_ONE = 1;

   // count accepted reads and writes, clear takes priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else if (clr_i) begin
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else begin
         if (rd_inc_i) rd_cnt_o <= rd_cnt_o + STATS_ONE;
         if (wr_inc_i) wr_cnt_o <= wr_cnt_o + STATS_ONE;
      end
   end

endmodule

// File: rtl/iob_native_responder.sv
// IOb Native responder in front of a single-port, byte-enabled RAM with
// one-cycle read latency. WAIT_CYCLES wait states precede each ready.
// Optional macro IOB_NATIVE_RESPONDER_STATS_EN adds read/write counters.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | no request in flight, outputs inactive
// ST_WAIT  | wait-state down-counter running
// ST_ACK   | ready high, RAM access issued
// ST_RDATA | read data from RAM presented with rvalid
module iob_native_responder
   import iob_native_responder_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 iob_avalid_i,
   input  logic [ADDR_W-1:0]                    iob_addr_i,
   input  logic [DATA_W-1:0]                    iob_wdata_i,
   input  logic [DATA_W/8-1:0]                  iob_wstrb_i,
   output logic                                 iob_ready_o,
   output logic                                 iob_rvalid_o,
   output logic [DATA_W-1:0]                    iob_rdata_o,
   output logic                                 mem_en_o,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]                    mem_wdata_o,
   output logic [DATA_W/8-1:0]                  mem_we_o,
   input  logic [DATA_W-1:0]                    mem_rdata_i
`ifdef IOB_NATIVE_RESPONDER_STATS_EN
   ,
   input  logic                                 stats_clr_i,
   output logic [STATS_W-1:0]                   rd_cnt_o,
   output logic [STATS_W-1:0]                   wr_cnt_o
`endif
);

   localparam int OFF_W = $clog2(DATA_W/8);
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // byte offset bits select nothing in a word-wide RAM
   generate
      if (OFF_W > 0) begin : g_off
         logic unused_addr_lsb;
         assign unused_addr_lsb = ^iob_addr_i[OFF_W-1:0];
      end
   endgenerate

   // state and wait counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state and state-decoded outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      iob_ready_o  = 1'b0;
      iob_rvalid_o = 1'b0;
      iob_rdata_o  = '0;
      mem_en_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_we_o     = '0;
      case (state_q)
         ST_IDLE: begin
            if (iob_avalid_i) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            // a dropped request abandons the transfer before any RAM access
            if (!iob_avalid_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_ACK: begin
            iob_ready_o = 1'b1;
            mem_en_o    = 1'b1;
            mem_addr_o  = iob_addr_i[ADDR_W-1:OFF_W];
            mem_wdata_o = iob_wdata_i;
            mem_we_o    = iob_wstrb_i;
            state_d     = (iob_wstrb_i == '0) ? ST_RDATA : ST_IDLE;
         end
         ST_RDATA: begin
            iob_rvalid_o = 1'b1;
            iob_rdata_o  = mem_rdata_i;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef IOB_NATIVE_RESPONDER_STATS_EN
   logic ack_rd, ack_wr;

   // classify the accepted request for the counters
   always_comb begin
      ack_rd = (state_q == ST_ACK) && (iob_wstrb_i == '0);
      ack_wr = (state_q == ST_ACK) && (iob_wstrb_i != '0);
   end

   iob_native_responder_stats u_stats (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (stats_clr_i),
      .rd_inc_i (ack_rd),
      .wr_inc_i (ack_wr),
      .rd_cnt_o (rd_cnt_o),
      .wr_cnt_o (wr_cnt_o)
   );
`endif

endmodule

// File: tb/tb_iob_native_responder.sv
// Bench for iob_native_responder: instance 0 with two wait states,
// instance 1 with none, each backed by a byte-enabled RAM.
module tb_iob_native_responder;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int NB = 4;
   localparam int WW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          avalid    [2];
   logic [AW-1:0] addr      [2];
   logic [DW-1:0] wdata     [2];
   logic [NB-1:0] wstrb     [2];
   logic          ready     [2];
   logic          rvalid    [2];
   logic [DW-1:0] rdata     [2];
   logic          mem_en    [2];
   logic [WW-1:0] mem_addr  [2];
   logic [DW-1:0] mem_wdata [2];
   logic [NB-1:0] mem_we    [2];
`ifdef IOB_NATIVE_RESPONDER_STATS_EN
   logic          clr       [2];
   logic [31:0]   rdc       [2];
   logic [31:0]   wrc       [2];
`endif

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [DW-1:0] ram [0:(1<<WW)-1];
      logic [DW-1:0] rd_q;

      initial begin
         for (int i = 0; i < (1<<WW); i++) ram[i] = '0;
         rd_q = '0;
      end

      iob_native_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .iob_avalid_i (avalid[g]),
         .iob_addr_i   (addr[g]),
         .iob_wdata_i  (wdata[g]),
         .iob_wstrb_i  (wstrb[g]),
         .iob_ready_o  (ready[g]),
         .iob_rvalid_o (rvalid[g]),
         .iob_rdata_o  (rdata[g]),
         .mem_en_o     (mem_en[g]),
         .mem_addr_o   (mem_addr[g]),
         .mem_wdata_o  (mem_wdata[g]),
         .mem_we_o     (mem_we[g]),
         .mem_rdata_i  (rd_q)
`ifdef IOB_NATIVE_RESPONDER_STATS_EN
         ,
         .stats_clr_i  (clr[g]),
         .rd_cnt_o     (rdc[g]),
         .wr_cnt_o     (wrc[g])
`endif
      );

      always @(posedge clk) begin
         if (mem_en[g]) begin
            for (int b = 0; b < NB; b++)
               if (mem_we[g][b]) ram[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            rd_q <= ram[mem_addr[g]];
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [int];

   function automatic int wc(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic int key(input int d, input logic [AW-1:0] a, input int b);
      return d * 65536 + (int'(a) / NB) * NB + b;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input int d, input logic [AW-1:0] a);
      logic [DW-1:0] r;
      r = '0;
      for (int b = 0; b < NB; b++)
         if (ref_mem.exists(key(d, a, b))) r[8*b +: 8] = ref_mem[key(d, a, b)];
      return r;
   endfunction

   function automatic void ref_wr(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                  input logic [NB-1:0] ws);
      for (int b = 0; b < NB; b++)
         if (ws[b]) ref_mem[key(d, a, b)] = wd[8*b +: 8];
   endfunction

   function automatic logic any_out(input int d);
      return ready[d] | rvalid[d] | mem_en[d] | (|mem_we[d]) | (|mem_addr[d])
           | (|mem_wdata[d]) | (|rdata[d]);
   endfunction

   // Issue one request from a negedge; returns the cycle numbers of ready
   // and rvalid (cycle 0 = edge sampling avalid), what the RAM saw at ACK,
   // and a count of protocol anomalies seen along the way.
   task automatic run_req(input int d, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [NB-1:0] ws, output int rk, output int vk,
                          output logic [DW-1:0] rd, output logic [WW-1:0] ack_a,
                          output logic [NB-1:0] ack_we, output logic [DW-1:0] ack_wd,
                          output int viol);
      rk = -1; vk = -1; rd = '0; ack_a = '0; ack_we = '0; ack_wd = '0; viol = 0;
      avalid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
      @(posedge clk);
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (rvalid[d] || rdata[d] !== '0) viol++;
         if (ready[d] === 1'b1) begin
            rk = k; ack_a = mem_addr[d]; ack_we = mem_we[d]; ack_wd = mem_wdata[d];
            if (mem_en[d] !== 1'b1) viol++;
            break;
         end else if (mem_en[d] || mem_we[d] !== '0 || mem_addr[d] !== '0 || mem_wdata[d] !== '0) viol++;
      end
      if (rk < 0) begin
         avalid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      avalid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      if (ready[d] || mem_en[d]) viol++;
      if (ws == '0) begin
         if (rvalid[d] === 1'b1) begin
            vk = rk + 1;
            rd = rdata[d];
         end
         @(posedge clk);
         @(negedge clk);
         if (rvalid[d] || rdata[d] !== '0) viol++;
      end else if (rvalid[d] || rdata[d] !== '0) viol++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int rk, vk, viol;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         avalid[d] = 1'b1; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            total++;
            if (any_out(d) !== 1'b0) begin
               bad++; $display("FAIL reset_outputs dut%0d cyc%0d got=%b want=0", d, i, any_out(d));
            end
         end
      end
`ifdef IOB_NATIVE_RESPONDER_STATS_EN
      total++;
      if ({rdc[0], wrc[0]} !== 64'd0) begin
         bad++; $display("FAIL reset_stats got=%h want=0", {rdc[0], wrc[0]});
      end
`endif
      avalid[1] = 1'b0;
      rst = 1'b0;
      run_req(0, '0, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (rk !== 3) begin bad++; $display("FAIL reset_release_ready got=%0d want=3", rk); end
      total++;
      if (viol !== 0) begin bad++; $display("FAIL reset_release_proto got=%0d want=0", viol); end
   endtask

   task automatic test_write_read();
      int rk, vk, viol;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      run_req(0, 14'h10, 32'hDEADBEEF, 4'hF, rk, vk, rd, aa, we, wd, viol);
      ref_wr(0, 14'h10, 32'hDEADBEEF, 4'hF);
      total++;
      if (aa !== 12'h4 || we !== 4'hF || wd !== 32'hDEADBEEF) begin
         bad++; $display("FAIL wr_ack_fields got=%h/%h/%h want=004/f/deadbeef", aa, we, wd);
      end
      total++;
      if (rk !== 3 || vk !== -1 || viol !== 0) begin
         bad++; $display("FAIL wr_timing got=%0d/%0d/%0d want=3/-1/0", rk, vk, viol);
      end
      run_req(0, 14'h10, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (aa !== 12'h4 || we !== 4'h0) begin
         bad++; $display("FAIL rd_ack_fields got=%h/%h want=004/0", aa, we);
      end
      total++;
      if (rk !== 3 || vk !== 4 || viol !== 0) begin
         bad++; $display("FAIL rd_timing got=%0d/%0d/%0d want=3/4/0", rk, vk, viol);
      end
      total++;
      if (rd !== 32'hDEADBEEF || rd !== ref_rd(0, 14'h10)) begin
         bad++; $display("FAIL rd_data got=%h want=deadbeef", rd);
      end
   endtask

   task automatic test_byte_write();
      int rk, vk, viol;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      run_req(0, 14'h20, 32'h11223344, 4'hF, rk, vk, rd, aa, we, wd, viol);
      ref_wr(0, 14'h20, 32'h11223344, 4'hF);
      run_req(0, 14'h20, 32'h000000AA, 4'h1, rk, vk, rd, aa, we, wd, viol);
      ref_wr(0, 14'h20, 32'h000000AA, 4'h1);
      run_req(0, 14'h20, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (rd !== 32'h112233AA || rd !== ref_rd(0, 14'h20)) begin
         bad++; $display("FAIL byte_write got=%h want=112233aa", rd);
      end
   endtask

   task automatic test_zero_wait();
      int rk, vk, viol, start, slow;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      run_req(1, 14'h8, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (rk !== 1 || vk !== 2 || viol !== 0) begin
         bad++; $display("FAIL zw_read_timing got=%0d/%0d/%0d want=1/2/0", rk, vk, viol);
      end
      slow = 0;
      start = cyc;
      for (int i = 0; i < 10; i++) begin
         run_req(1, AW'(4*i), DW'(i), 4'hF, rk, vk, rd, aa, we, wd, viol);
         ref_wr(1, AW'(4*i), DW'(i), 4'hF);
         if (rk != 1 || viol != 0) slow++;
      end
      total++;
      if (cyc - start !== 20 || slow !== 0) begin
         bad++; $display("FAIL zw_b2b_writes got=%0d cycles/%0d slow want=20/0", cyc - start, slow);
      end
      run_req(1, 14'd28, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (rd !== 32'd7 || rd !== ref_rd(1, 14'd28)) begin
         bad++; $display("FAIL zw_readback got=%h want=7", rd);
      end
   endtask

   task automatic test_random();
      int rk, vk, viol;
      logic [DW-1:0] rd, wd, dat, exp;
      logic [WW-1:0] aa;
      logic [NB-1:0] we, ws;
      logic [AW-1:0] a;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 30; n++) begin
            a   = AW'(16'h100 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            dat = DW'($urandom);
            ws  = ($urandom_range(0, 2) == 0) ? 4'h0 : NB'($urandom_range(1, 15));
            exp = ref_rd(d, a);
            run_req(d, a, dat, ws, rk, vk, rd, aa, we, wd, viol);
            total++;
            if (rk !== wc(d) + 1 || viol !== 0) begin
               bad++; $display("FAIL rand_ready dut%0d n%0d got=%0d/%0d want=%0d/0", d, n, rk, viol, wc(d) + 1);
            end
            total++;
            if (aa !== a[AW-1:2] || we !== ws || wd !== (ws == '0 ? dat : dat)) begin
               bad++; $display("FAIL rand_ack dut%0d n%0d got=%h/%h/%h want=%h/%h/%h", d, n, aa, we, wd, a[AW-1:2], ws, dat);
            end
            if (ws == '0) begin
               total++;
               if (vk !== wc(d) + 2 || rd !== exp) begin
                  bad++; $display("FAIL rand_read dut%0d n%0d got=%0d/%h want=%0d/%h", d, n, vk, rd, wc(d) + 2, exp);
               end
            end else begin
               ref_wr(d, a, dat, ws);
               total++;
               if (vk !== -1) begin
                  bad++; $display("FAIL rand_write_rvalid dut%0d n%0d got=%0d want=-1", d, n, vk);
               end
            end
         end
      end
   endtask

   task automatic test_abort();
      int rk, vk, viol, seen;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      avalid[0] = 1'b1; addr[0] = 14'h60; wdata[0] = 32'h55; wstrb[0] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      avalid[0] = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_en[0] || ready[0]) seen++;
      end
      wstrb[0] = '0; wdata[0] = '0; addr[0] = '0;
      total++;
      if (seen !== 0) begin bad++; $display("FAIL abort_no_access got=%0d want=0", seen); end
      run_req(0, 14'h60, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (rk !== 3 || rd !== ref_rd(0, 14'h60)) begin
         bad++; $display("FAIL abort_recover got=%0d/%h want=3/%h", rk, rd, ref_rd(0, 14'h60));
      end
   endtask

   task automatic test_reset_in_ack();
      int rk, vk, viol, seen;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            run_req(0, 14'h50, 32'h01020304, 4'hF, rk, vk, rd, aa, we, wd, viol);
            ref_wr(0, 14'h50, 32'h01020304, 4'hF);
         end
         avalid[0] = 1'b1; addr[0] = (pass == 0) ? 14'h40 : 14'h50;
         wdata[0] = (pass == 0) ? 32'h0 : 32'hFFFFFFFF;
         wstrb[0] = (pass == 0) ? 4'h0 : 4'hF;
         @(posedge clk);
         seen = 0;
         for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (ready[0] === 1'b1) seen = 1;
         end
         total++;
         if (seen !== 1) begin bad++; $display("FAIL rst_ack_reach pass%0d got=%0d want=1", pass, seen); end
         rst = 1'b1;
         #1;
         total++;
         if (any_out(0) !== 1'b0) begin bad++; $display("FAIL rst_ack_outputs pass%0d got=%b want=0", pass, any_out(0)); end
         @(negedge clk);
         @(negedge clk);
         avalid[0] = 1'b0; addr[0] = '0; wdata[0] = '0; wstrb[0] = '0;
         rst = 1'b0;
         seen = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid[0] || mem_en[0]) seen++;
         end
         total++;
         if (seen !== 0) begin bad++; $display("FAIL rst_ack_quiet pass%0d got=%0d want=0", pass, seen); end
      end
      run_req(0, 14'h50, '0, '0, rk, vk, rd, aa, we, wd, viol);
      total++;
      if (rd !== 32'h01020304 || rd !== ref_rd(0, 14'h50)) begin
         bad++; $display("FAIL rst_ack_no_write got=%h want=01020304", rd);
      end
   endtask

`ifdef IOB_NATIVE_RESPONDER_STATS_EN
   task automatic test_stats();
      int rk, vk, viol;
      logic [DW-1:0] rd, wd;
      logic [WW-1:0] aa;
      logic [NB-1:0] we;
      clr[1] = 1'b1;
      @(negedge clk);
      clr[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1 || i == 3) begin
            run_req(1, AW'(16'h200 + 4*i), DW'($urandom), 4'hF, rk, vk, rd, aa, we, wd, viol);
            ref_wr(1, AW'(16'h200 + 4*i), wd, 4'hF);
         end else begin
            run_req(1, AW'(16'h200 + 4*i), '0, '0, rk, vk, rd, aa, we, wd, viol);
         end
      end
      total++;
      if (rdc[1] !== 32'd3 || wrc[1] !== 32'd2) begin
         bad++; $display("FAIL stats_counts got=%0d/%0d want=3/2", rdc[1], wrc[1]);
      end
      avalid[1] = 1'b1; addr[1] = 14'h200; wdata[1] = '0; wstrb[1] = '0;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (ready[1] !== 1'b1) begin bad++; $display("FAIL stats_clr_ack got=%b want=1", ready[1]); end
      clr[1] = 1'b1;
      @(negedge clk);
      clr[1] = 1'b0; avalid[1] = 1'b0; addr[1] = '0;
      total++;
      if (rdc[1] !== 32'd0 || wrc[1] !== 32'd0) begin
         bad++; $display("FAIL stats_clr_priority got=%0d/%0d want=0/0", rdc[1], wrc[1]);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      for (int d = 0; d < 2; d++) begin
         avalid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
`ifdef IOB_NATIVE_RESPONDER_STATS_EN
         clr[d] = 1'b0;
`endif
      end
      @(negedge clk);
      test_reset();
      test_write_read();
      test_byte_write();
      test_zero_wait();
      test_random();
      test_abort();
      test_reset_in_ack();
`ifdef IOB_NATIVE_RESPONDER_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
